mux_scan_sequencer: RTL and testbench
=====================================

# mux_scan_sequencer

Channel scanner that sits directly in front of the 8:1 mux tree and behind it. It drives the tree's three select lines through channels 0..7 and waits a programmable settle time on each channel. It samples the tree's single-bit output and assembles the eight samples into one byte. The byte is handed downstream over a valid/ready handshake.

## Interface

Parameters:
- SETTLE_CYCLES, default 1: cycles the select lines are held stable before each sample; legal range 1..15; 0 is not supported.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request one 8-channel scan; sampled only in IDLE.
- mux_out  input  1  output of the 8:1 mux tree.
- s0  output  1  tree select, index bit 2 (MSB).
- s1  output  1  tree select, index bit 1.
- s2  output  1  tree select, index bit 0 (LSB).
- data  output  8  assembled byte; bit i = sample of channel i (channel 0 = input A … channel 7 = input H).
- valid  output  1  data holds a new byte.
- ready  input  1  downstream accepts data.
- busy  output  1  high in SETTLE and SAMPLE states.

## Operation

- Internal state: 3-bit channel index idx, settle counter cnt (4 bits), 8-bit capture register cap, 8-bit output register data.
- Select mapping: {s0,s1,s2} = idx at all times.
- States and transitions:
  - IDLE: idx=0, valid=0. If start=1 → SETTLE, cnt=SETTLE_CYCLES.
  - SETTLE: cnt decrements each cycle; leaves to SAMPLE on the edge where cnt==1. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
  - SAMPLE: one cycle. On its closing edge cap[idx]=mux_out.
    - If idx==7: data=cap with bit 7 replaced by mux_out, valid=1, idx=0 → HOLD.
    - Otherwise: idx=idx+1, cnt=SETTLE_CYCLES → SETTLE.
  - HOLD: valid=1 and data stable. On an edge with ready=1 → IDLE and valid=0. With the macro enabled, see Configuration.
- start is ignored outside IDLE; no request queuing.
- data retains the previous byte throughout a scan; it is updated only on HOLD entry.
- idx wraps 7→0 only via the HOLD transition; it never increments past 7.
- A ready value seen outside HOLD has no effect.

## Timing

- Reset (rst_n=0, asynchronous, also mid-scan): state=IDLE, idx=0, cnt=0, cap=0, data=0x00, valid=0, busy=0, s0=s1=s2=0. The partial scan is discarded.
- Scan latency: with start sampled at edge k, valid is high after edge k+8·(SETTLE_CYCLES+1). For SETTLE_CYCLES=1 this is edge k+16.
- Select lines change only on the edge that closes a SAMPLE cycle. The next sample therefore comes SETTLE_CYCLES+1 edges later.
- busy rises after edge k and falls on HOLD entry.
- Handshake: the transfer occurs on an edge with valid=1 and ready=1. valid drops after that edge unless a new byte is loaded on the same edge (macro case).
- valid stays high for at least one cycle, even if ready is already high.
- Throughput without the macro: a new scan needs start in IDLE. Minimum period is 8·(SETTLE_CYCLES+1)+2 cycles.

## Configuration

- SCAN_CONTINUOUS_EN
  - Defined: on the HOLD handshake edge the FSM goes directly to SETTLE with idx=0 and cnt=SETTLE_CYCLES; start is not required. busy rises on the same edge and valid falls. Scanning repeats until reset. The first scan still requires start.
  - Undefined: HOLD → IDLE on handshake, and the next scan needs a new start.

## Test plan

- Reset mid-scan: assert rst_n=0 at edge 5 after start → all outputs at reset values immediately. A fresh start with inputs A..H=1,0,1,0,0,1,0,1 yields data=0xA5.
- Latency, SETTLE_CYCLES=1: start pulse at edge 10 → valid first high after edge 26; busy high over edges 11–26; select sequence 0,1,…,7 with 2 cycles per value.
- SETTLE_CYCLES=3, inputs 0x3C: valid after 32 cycles and data=0x3C. Changing input C during its settle window but before its SAMPLE edge is reflected in the captured bit.
- Backpressure: ready=0 for 20 cycles in HOLD → valid and data stay constant. start pulses during HOLD are ignored. ready=1 → valid=0 on the next edge.
- ready held high throughout: valid is high for exactly 1 cycle per byte. Without the macro, busy stays low until the next start.
- With SCAN_CONTINUOUS_EN, SETTLE_CYCLES=1: inputs changed between scans 0x0F→0xF0 → consecutive bytes 0x0F then 0xF0, one valid pulse every 17 cycles with ready=1.

Source files
------------

// File: rtl/mux_scan_sequencer_if.sv
// rtl/mux_scan_sequencer_if.sv - mux-select, sample input and byte handshake bundle for mux_scan_sequencer
interface mux_scan_sequencer_if;
  logic       start;
  logic       mux_out;
  logic       s0;
  logic       s1;
  logic       s2;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       busy;

  modport master (
    input  start, mux_out, ready,
    output s0, s1, s2, data, valid, busy
  );

  modport slave (
    output start, mux_out, ready,
    input  s0, s1, s2, data, valid, busy
  );
endinterface

// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - steps an 8:1 mux tree through channels 0..7 and packs the samples into a byte
// Optional feature: SCAN_CONTINUOUS_EN restarts the scan on every HOLD handshake.
module mux_scan_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux_scan_sequencer_if.master bus
);
  localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_HOLD
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [2:0] r_idx, w_idx_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_cap, w_cap_nxt;
  logic [7:0] r_data, w_data_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= 3'd0;
      r_cnt   <= 4'd0;
      r_cap   <= 8'h00;
      r_data  <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cap   <= w_cap_nxt;
      r_data  <= w_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_cap_nxt   = r_cap;
    w_data_nxt  = r_data;
    case (r_state)
      ST_IDLE: begin
        w_idx_nxt = 3'd0;
        if (bus.start) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = LP_SETTLE;
        end
      end
      ST_SETTLE: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        w_cap_nxt[r_idx] = bus.mux_out;
        // Channel 7 is still only on the mux output, so it bypasses cap into data.
        if (r_idx == 3'd7) begin
          w_data_nxt  = {bus.mux_out, r_cap[6:0]};
          w_idx_nxt   = 3'd0;
          w_state_nxt = ST_HOLD;
        end else begin
          w_idx_nxt   = r_idx + 3'd1;
          w_cnt_nxt   = LP_SETTLE;
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_HOLD: begin
        if (bus.ready) begin
`ifdef SCAN_CONTINUOUS_EN
          w_state_nxt = ST_SETTLE;
          w_idx_nxt   = 3'd0;
          w_cnt_nxt   = LP_SETTLE;
`else
          w_state_nxt = ST_IDLE;
`endif
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.s0    = r_idx[2];
  assign bus.s1    = r_idx[1];
  assign bus.s2    = r_idx[0];
  assign bus.data  = r_data;
  assign bus.valid = (r_state == ST_HOLD);
  assign bus.busy  = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb/tb_mux_scan_sequencer.sv - directed bench for mux_scan_sequencer at settle times 1 and 3
module tb_mux_scan_sequencer;
  logic       clk;
  logic       rst_n;
  logic [7:0] in1;
  logic [7:0] in3;
  logic [2:0] sel1;
  logic [2:0] sel3;
  int         n_checks;
  int         n_pass;

  mux_scan_sequencer_if if1 ();
  mux_scan_sequencer_if if3 ();

  mux_scan_sequencer #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.master));
  mux_scan_sequencer #(.SETTLE_CYCLES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.master));

  assign sel1        = {if1.s0, if1.s1, if1.s2};
  assign sel3        = {if3.s0, if3.s1, if3.s2};
  assign if1.mux_out = in1[sel1];
  assign if3.mux_out = in3[sel3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int which, input int max, output int n);
    n = 0;
    while (((which == 1) ? if1.valid : if3.valid) == 1'b0 && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic pulse_start(input int which);
    if (which == 1) if1.start = 1'b1;
    else if3.start = 1'b1;
    tick();
    if1.start = 1'b0;
    if3.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int bad;
    int vcnt;
    int bcnt;
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    if1.start = 1'b0;
    if3.start = 1'b0;
    if1.ready = 1'b0;
    if3.ready = 1'b0;
    in1       = 8'hFF;
    in3       = 8'h3C;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("rst_data", 32'(if1.data), 32'h00);
    check("rst_valid", 32'(if1.valid), 32'h0);
    check("rst_busy", 32'(if1.busy), 32'h0);
    check("rst_sel", 32'(sel1), 32'h0);

    // reset asserted five edges into a scan
    pulse_start(1);
    repeat (5) tick();
    check("mid_sel", 32'(sel1), 32'h2);
    check("mid_busy", 32'(if1.busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(if1.busy), 32'h0);
    check("arst_sel", 32'(sel1), 32'h0);
    check("arst_valid", 32'(if1.valid), 32'h0);
    check("arst_data", 32'(if1.data), 32'h00);
    tick();
    rst_n = 1'b1;
    in1   = 8'hA5;
    tick();
    pulse_start(1);
    wait_valid(1, 40, n);
    check("a5_latency", 32'(n), 32'd16);
    check("a5_data", 32'(if1.data), 32'hA5);
    if1.ready = 1'b1;
    tick();
    if1.ready = 1'b0;
    check("a5_drop", 32'(if1.valid), 32'h0);

    // latency and select sequence, one check per edge
    in1 = 8'h5A;
    repeat (2) tick();
    pulse_start(1);
    check("lat_busy_0", 32'(if1.busy), 32'h1);
    check("lat_sel_0", 32'(sel1), 32'h0);
    for (int j = 1; j <= 16; j++) begin
      tick();
      check($sformatf("lat_busy_%0d", j), 32'(if1.busy), (j < 16) ? 32'h1 : 32'h0);
      check($sformatf("lat_valid_%0d", j), 32'(if1.valid), (j == 16) ? 32'h1 : 32'h0);
      check($sformatf("lat_sel_%0d", j), 32'(sel1), (j < 16) ? 32'(j / 2) : 32'h0);
    end
    check("lat_data", 32'(if1.data), 32'h5A);
    if1.ready = 1'b1;
    tick();
    if1.ready = 1'b0;

    // backpressure with ignored start pulses
    in1 = 8'hC3;
    tick();
    pulse_start(1);
    check("bp_old_data", 32'(if1.data), 32'h5A);
    wait_valid(1, 40, n);
    check("bp_data", 32'(if1.data), 32'hC3);
    in1 = 8'h00;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if1.start = (i % 3 == 0);
      tick();
      if1.start = 1'b0;
      if (!if1.valid || if1.data != 8'hC3 || if1.busy) bad++;
    end
    check("bp_stable", 32'(bad), 32'd0);
    if1.ready = 1'b1;
    tick();
    check("bp_release", 32'(if1.valid), 32'h0);
    repeat (3) tick();
    check("bp_no_queue", 32'(if1.busy), 32'h0);

`ifdef SCAN_CONTINUOUS_EN
    in1 = 8'h0F;
    pulse_start(1);
    wait_valid(1, 40, n);
    check("cont_first_lat", 32'(n), 32'd16);
    check("cont_first", 32'(if1.data), 32'h0F);
    in1 = 8'hF0;
    tick();
    check("cont_busy", 32'(if1.busy), 32'h1);
    check("cont_drop", 32'(if1.valid), 32'h0);
    n = 1;
    while (!if1.valid && n < 40) begin
      tick();
      n++;
    end
    check("cont_period", 32'(n), 32'd17);
    check("cont_second", 32'(if1.data), 32'hF0);
`else
    in1  = 8'h81;
    vcnt = 0;
    bcnt = 0;
    pulse_start(1);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (if1.valid) vcnt++;
      if (i >= 20 && if1.busy) bcnt++;
    end
    check("rdy_valid_cycles", 32'(vcnt), 32'd1);
    check("rdy_data", 32'(if1.data), 32'h81);
    check("rdy_idle_busy", 32'(bcnt), 32'd0);
`endif

    // settle time 3
    pulse_start(3);
    wait_valid(3, 60, n);
    check("s3_latency", 32'(n), 32'd32);
    check("s3_data", 32'(if3.data), 32'h3C);
    if3.ready = 1'b1;
    tick();
    if3.ready = 1'b0;
    check("s3_drop", 32'(if3.valid), 32'h0);
    pulse_start(3);
    n = 0;
    while (sel3 != 3'd2 && n < 20) begin
      tick();
      n++;
    end
    check("s3_reach_c", 32'(sel3), 32'h2);
    in3[2] = 1'b0;
    wait_valid(3, 60, n);
    check("s3_settle_change", 32'(if3.data), 32'h38);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
